// File: rtl/spi_cmd_seq.sv
// spi_cmd_seq: command sequencer that sits between the SPI byte shifter and the register bank.
// Each chip-select period carries one command byte followed by data bytes. The block issues
// single-cycle read/write strobes, preloads the next transmit byte, and supports auto-increment
// bursts with address wrap and invalid-address flagging.
module spi_cmd_seq #(
  parameter logic [7:0] CHIP_ID  = 8'h07,
  parameter int         NUM_REGS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs_active,
  input  logic       byte_valid,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic [2:0] reg_addr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       reg_wr,
  output logic [7:0] reg_wdata,
  output logic       busy,
  output logic       err,
  output logic [7:0] xfer_count
);

  typedef enum logic [2:0] {IDLE, CMD, RDATA, WDATA, DRAIN} state_t;

  state_t      state_q, state_d;
  logic        cs_prev_q;
  logic        inc_q, inc_d;
  logic [2:0]  addr_q, addr_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  dout_q, dout_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  // An invalid prefetch loads 8'hFF one edge later, in step with a real read's data.
  logic        rd_inv_q, rd_inv_d;
  // A burst write advances the address only after its strobe cycle, so the strobe sees the old address.
  logic        adv_q, adv_d;
  logic        unused_cmd_bits;

  assign unused_cmd_bits = ^din[5:3];

  function automatic logic addr_ok(input logic [2:0] a);
    return int'(a) < NUM_REGS;
  endfunction

  // In-range addresses wrap from NUM_REGS-1 to 0. Out-of-range addresses step +1 mod 8.
  function automatic logic [2:0] next_addr(input logic [2:0] a);
    return (int'(a) == NUM_REGS - 1) ? 3'd0 : a + 3'd1;
  endfunction

  // Next-state and datapath decode; cs_active low overrides any coincident byte.
  always_comb begin
    state_d  = state_q;
    inc_d    = inc_q;
    addr_d   = addr_q;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    wdata_d  = wdata_q;
    dout_d   = dout_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    rd_inv_d = 1'b0;
    adv_d    = 1'b0;

    if (rd_q)     dout_d = reg_rdata;
    if (rd_inv_q) dout_d = 8'hFF;
    if (adv_q)    addr_d = next_addr(addr_q);

    if (!cs_active) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!cs_prev_q) begin
            state_d = CMD;
            err_d   = 1'b0;
            dout_d  = CHIP_ID;
          end
        end
        CMD: begin
          if (byte_valid) begin
            addr_d = din[2:0];
            inc_d  = din[6];
            cnt_d  = cnt_q + 8'd1;
            if (din[7]) begin
              state_d = RDATA;
              if (addr_ok(din[2:0])) rd_d = 1'b1;
              else begin rd_inv_d = 1'b1; err_d = 1'b1; end
            end else begin
              state_d = WDATA;
            end
          end
        end
        RDATA: begin
          if (byte_valid) begin
            if (inc_q) begin
              addr_d = next_addr(addr_q);
              if (addr_ok(next_addr(addr_q))) rd_d = 1'b1;
              else begin rd_inv_d = 1'b1; err_d = 1'b1; end
            end else begin
              state_d = DRAIN;
            end
          end
        end
        WDATA: begin
          if (byte_valid) begin
            if (addr_ok(addr_q)) begin wr_d = 1'b1; wdata_d = din; end
            else err_d = 1'b1;
            dout_d = din;
            if (inc_q) adv_d = 1'b1;
            else state_d = DRAIN;
          end
        end
        DRAIN: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers, cleared immediately by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cs_prev_q <= 1'b0;
      inc_q     <= 1'b0;
      addr_q    <= 3'd0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      wdata_q   <= 8'd0;
      dout_q    <= CHIP_ID;
      err_q     <= 1'b0;
      cnt_q     <= 8'd0;
      rd_inv_q  <= 1'b0;
      adv_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cs_prev_q <= cs_active;
      inc_q     <= inc_d;
      addr_q    <= addr_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      dout_q    <= dout_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      rd_inv_q  <= rd_inv_d;
      adv_q     <= adv_d;
    end
  end

  assign dout       = dout_q;
  assign reg_addr   = addr_q;
  assign reg_rd     = rd_q;
  assign reg_wr     = wr_q;
  assign reg_wdata  = wdata_q;
  assign busy       = (state_q != IDLE);
  assign err        = err_q;
  assign xfer_count = cnt_q;

endmodule

// File: tb/tb_spi_cmd_seq.sv
// Directed bench for spi_cmd_seq: expected strobes are queued as stimulus is driven and
// popped by a monitor when the DUT issues reg_rd / reg_wr.
module tb_spi_cmd_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       cs_active;
  logic       byte_valid;
  logic [7:0] din;
  logic [7:0] dout;
  logic [2:0] reg_addr;
  logic       reg_rd;
  logic [7:0] reg_rdata;
  logic       reg_wr;
  logic [7:0] reg_wdata;
  logic       busy;
  logic       err;
  logic [7:0] xfer_count;

  int n_chk  = 0;
  int n_fail = 0;
  int wr_seen = 0;
  int rd_seen = 0;

  logic [10:0] wr_exp[$];
  logic [2:0]  rd_exp[$];
  logic [7:0]  mem [8];

  spi_cmd_seq dut (
    .clk        (clk),
    .rst        (rst),
    .cs_active  (cs_active),
    .byte_valid (byte_valid),
    .din        (din),
    .dout       (dout),
    .reg_addr   (reg_addr),
    .reg_rd     (reg_rd),
    .reg_rdata  (reg_rdata),
    .reg_wr     (reg_wr),
    .reg_wdata  (reg_wdata),
    .busy       (busy),
    .err        (err),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  assign reg_rdata = mem[reg_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor: every strobe must match the head of its expectation queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (reg_rd && reg_wr) check("rd_wr_both", 32'd1, 32'd0);
      if (reg_wr) begin
        wr_seen++;
        if (wr_exp.size() == 0) check("unexpected_wr", 32'(reg_addr), 32'hFFFF);
        else check("wr_addr_data", 32'({reg_addr, reg_wdata}), 32'(wr_exp.pop_front()));
      end
      if (reg_rd) begin
        rd_seen++;
        if (rd_exp.size() == 0) check("unexpected_rd", 32'(reg_addr), 32'hFFFF);
        else check("rd_addr", 32'(reg_addr), 32'(rd_exp.pop_front()));
      end
    end
  end

  // Byte arrives in the cycle before a posedge; returns at the negedge in the strobe cycle.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    din = b;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_start();
    @(negedge clk);
    cs_active = 1'b1;
    idle(2);
  endtask

  task automatic cs_end();
    @(negedge clk);
    cs_active = 1'b0;
    idle(2);
  endtask

  initial begin
    int w0;
    mem[0] = 8'h10; mem[1] = 8'h3C; mem[2] = 8'h22; mem[3] = 8'h33;
    mem[4] = 8'h4D; mem[5] = 8'h00; mem[6] = 8'h00; mem[7] = 8'h00;
    rst = 1'b1; cs_active = 1'b0; byte_valid = 1'b0; din = 8'h00;
    idle(3);
    check("rst_dout",  32'(dout), 32'h07);
    check("rst_addr",  32'(reg_addr), 32'd0);
    check("rst_rd",    32'(reg_rd), 32'd0);
    check("rst_wr",    32'(reg_wr), 32'd0);
    check("rst_wdata", 32'(reg_wdata), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_err",   32'(err), 32'd0);
    check("rst_cnt",   32'(xfer_count), 32'd0);
    rst = 1'b0;
    idle(2);

    // Single read of register 1, then a dummy byte into DRAIN.
    cs_start();
    check("cs_busy", 32'(busy), 32'd1);
    check("cs_dout", 32'(dout), 32'h07);
    rd_exp.push_back(3'd1);
    send_byte(8'h81);
    check("rd1_addr", 32'(reg_addr), 32'd1);
    check("rd1_cnt", 32'(xfer_count), 32'd1);
    idle(1);
    check("rd1_dout", 32'(dout), 32'h3C);
    idle(3);
    send_byte(8'h00);
    idle(3);
    check("drain_busy", 32'(busy), 32'd1);
    check("drain_dout", 32'(dout), 32'h3C);
    check("rd1_count", 32'(rd_seen), 32'd1);
    cs_end();
    check("idle_busy", 32'(busy), 32'd0);

    // Single write of A5 to register 3.
    cs_start();
    wr_exp.push_back({3'd3, 8'hA5});
    send_byte(8'h03);
    idle(3);
    send_byte(8'hA5);
    check("wr1_echo", 32'(dout), 32'hA5);
    check("wr1_err", 32'(err), 32'd0);
    check("wr1_cnt", 32'(xfer_count), 32'd2);
    idle(3);
    cs_end();

    // Burst write from 3 wrapping through 4 to 0.
    w0 = wr_seen;
    cs_start();
    wr_exp.push_back({3'd3, 8'h11});
    wr_exp.push_back({3'd4, 8'h22});
    wr_exp.push_back({3'd0, 8'h33});
    send_byte(8'h43);
    for (int i = 0; i < 3; i++) begin
      idle(3);
      send_byte(8'h11 * (i + 1));
    end
    idle(3);
    check("burst_wr_count", 32'(wr_seen - w0), 32'd3);
    check("burst_addr_wrapped", 32'(reg_addr), 32'd1);
    check("burst_cnt", 32'(xfer_count), 32'd3);
    cs_end();

    // Invalid address write: no strobe, sticky err until the next cs rising.
    w0 = wr_seen;
    cs_start();
    send_byte(8'h06);
    idle(3);
    send_byte(8'h55);
    check("inv_err", 32'(err), 32'd1);
    check("inv_echo", 32'(dout), 32'h55);
    idle(3);
    check("inv_no_wr", 32'(wr_seen - w0), 32'd0);
    cs_end();
    check("inv_err_sticky", 32'(err), 32'd1);
    @(negedge clk);
    cs_active = 1'b1;
    @(negedge clk);
    check("inv_err_cleared", 32'(err), 32'd0);
    idle(1);

    // Abort: cs drops on the same edge as the data byte.
    send_byte(8'h04);
    idle(3);
    check("abort_cnt", 32'(xfer_count), 32'd5);
    @(negedge clk);
    din = 8'hAA; byte_valid = 1'b1; cs_active = 1'b0;
    @(negedge clk);
    byte_valid = 1'b0;
    idle(2);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_no_wr", 32'(wr_seen - w0), 32'd0);
    check("abort_cnt_after", 32'(xfer_count), 32'd5);

    // Read burst from 4 wrapping to 0.
    cs_start();
    rd_exp.push_back(3'd4);
    send_byte(8'hC4);
    idle(1);
    check("rburst_dout4", 32'(dout), 32'h4D);
    idle(2);
    rd_exp.push_back(3'd0);
    send_byte(8'h00);
    check("rburst_addr0", 32'(reg_addr), 32'd0);
    idle(1);
    check("rburst_dout0", 32'(dout), 32'h10);
    idle(2);
    cs_end();

    // Asynchronous reset in the middle of a burst write.
    cs_start();
    wr_exp.push_back({3'd2, 8'h77});
    send_byte(8'h42);
    idle(3);
    send_byte(8'h77);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_dout", 32'(dout), 32'h07);
    check("arst_addr", 32'(reg_addr), 32'd0);
    check("arst_cnt",  32'(xfer_count), 32'd0);
    check("arst_wr",   32'(reg_wr), 32'd0);
    @(negedge clk);
    cs_active = 1'b0;
    rst = 1'b0;
    idle(2);

    check("wr_queue_empty", 32'(wr_exp.size()), 32'd0);
    check("rd_queue_empty", 32'(rd_exp.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
